// File: rtl/divisor_arbiter.sv
// Round-robin arbiter sharing one multi-cycle divisor between two requesters.
// Optional macro DIV_ZERO_CHECK_EN answers b==0 requests locally without using the divisor.
module divisor_arbiter #(
  parameter int W           = 4,
  parameter int DIV_LATENCY = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp_valid,
  output logic         rsp_id,
  output logic [W-1:0] rsp_q,
  output logic [W-1:0] rsp_r,
  output logic         rsp_err,
  output logic         div_rst,
  output logic [W-1:0] div_a,
  output logic [W-1:0] div_b,
  input  logic [W-1:0] div_s,
  input  logic [W-1:0] div_r
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int CNT_W = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_LATENCY - 1);

  state_e         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           last_grant_q, last_grant_d;
  logic           owner_q, owner_d;
  logic [W-1:0]   div_a_q, div_a_d;
  logic [W-1:0]   div_b_q, div_b_d;
  logic           rsp_id_q, rsp_id_d;
  logic [W-1:0]   rsp_q_q, rsp_q_d;
  logic [W-1:0]   rsp_r_q, rsp_r_d;
  logic           rsp_err_q, rsp_err_d;

  logic           grant_vld;
  logic           grant_id;
  logic [W-1:0]   sel_a;
  logic [W-1:0]   sel_b;
  logic           zero_hit;
  logic           run_last;

  // Both valid: alternate away from the previous winner; otherwise the lone requester wins.
  assign grant_vld = (state_q == IDLE) && !rst && (req0_valid || req1_valid);
  assign grant_id  = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
  assign sel_a     = grant_id ? req1_a : req0_a;
  assign sel_b     = grant_id ? req1_b : req0_b;
  assign run_last  = (state_q == RUN) && (cnt_q == CNT_LAST);

`ifdef DIV_ZERO_CHECK_EN
  assign zero_hit = (sel_b == '0);
`else
  assign zero_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          state_d = zero_hit ? DONE : LOAD;
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        if (run_last) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = grant_vld && !grant_id;
    req1_ready = grant_vld && grant_id;
    div_rst    = (state_q == LOAD);
    rsp_valid  = (state_q == DONE);
  end

  // Datapath next-state: operands latch on accept, results latch on the edge entering DONE.
  always_comb begin
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    div_a_d      = div_a_q;
    div_b_d      = div_b_q;
    rsp_id_d     = rsp_id_q;
    rsp_q_d      = rsp_q_q;
    rsp_r_d      = rsp_r_q;
    rsp_err_d    = rsp_err_q;
    if (grant_vld) begin
      last_grant_d = grant_id;
      owner_d      = grant_id;
      div_a_d      = sel_a;
      div_b_d      = sel_b;
      if (zero_hit) begin
        rsp_id_d  = grant_id;
        rsp_q_d   = '1;
        rsp_r_d   = sel_a;
        rsp_err_d = 1'b1;
      end
    end
    if (state_q == LOAD) begin
      cnt_d = '0;
    end else if (state_q == RUN) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (run_last) begin
      rsp_id_d  = owner_q;
      rsp_q_d   = div_s;
      rsp_r_d   = div_r;
      rsp_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      div_a_q      <= '0;
      div_b_q      <= '0;
      rsp_id_q     <= 1'b0;
      rsp_q_q      <= '0;
      rsp_r_q      <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      div_a_q      <= div_a_d;
      div_b_q      <= div_b_d;
      rsp_id_q     <= rsp_id_d;
      rsp_q_q      <= rsp_q_d;
      rsp_r_q      <= rsp_r_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign div_a   = div_a_q;
  assign div_b   = div_b_q;
  assign rsp_id  = rsp_id_q;
  assign rsp_q   = rsp_q_q;
  assign rsp_r   = rsp_r_q;
  assign rsp_err = rsp_err_q;

endmodule
